ml_accel_master: RTL and testbench

Bus initiator for the ML accelerator register interface: it accepts one dot-product job as a stream of operand words, writes them into the accelerator's operand registers, triggers the computation, polls for completion, and returns the result on a valid/ready output. It sits between a job source (CPU-side FIFO or a sequencer) and the accelerator's `addr`/`w_data`/`w_en`/`r_en`/`r_data` port, replacing software-driven register pokes.

---
 rtl/ml_accel_master.sv | 162 ++++++++++++++++
 tb/tb_ml_accel_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_accel_master.sv
// Bus initiator for the ML accelerator: streams one dot-product job into the
// operand registers, triggers it, polls DONE and returns the result on valid/ready.
module ml_accel_master #(
  parameter int              VEC_LEN     = 4,
  parameter int              ADDR_W      = 6,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = 'h20,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = 'h24,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 'h28,
  parameter int              DONE_BIT    = 0,
  parameter int              MAX_POLLS   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] w_data,
  output logic              w_en,
  output logic              r_en,
  input  logic [DATA_W-1:0] r_data
);

  localparam int NWORDS = 2 * VEC_LEN;
  localparam int IDX_W  = $clog2(NWORDS) + 1;
  localparam int PCNT_W = ($clog2(MAX_POLLS + 1) > 8) ? $clog2(MAX_POLLS + 1) : 8;

  typedef enum logic [2:0] {
    IDLE, LOAD, TRIG, POLL, POLL_WAIT, RD, RD_WAIT, RESP
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [PCNT_W-1:0]   poll_q;
  logic                op_ready_q;
  logic                res_valid_q;
  logic                res_timeout_q;
  logic                busy_q;
  logic                w_en_q;
  logic                r_en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W-1:0]   res_data_q;

  logic                op_fire;
  logic [IDX_W-1:0]    idx_d;
  logic [PCNT_W-1:0]   poll_d;
  logic [ADDR_W-1:0]   idx_addr;

  assign op_fire  = op_valid && op_ready_q;
  assign idx_d    = idx_q + 1'b1;
  assign poll_d   = poll_q + 1'b1;
  assign idx_addr = ADDR_W'({idx_q, 2'b00});

  // Each state names the bus activity presented during it; r_data is sampled
  // in the *_WAIT states, one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      poll_q        <= '0;
      op_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      w_en_q        <= 1'b0;
      r_en_q        <= 1'b0;
      addr_q        <= '0;
      w_data_q      <= '0;
      res_data_q    <= '0;
    end else begin
      w_en_q <= 1'b0;
      r_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          op_ready_q <= 1'b1;
          if (op_fire) begin
            w_en_q   <= 1'b1;
            addr_q   <= '0;
            w_data_q <= op_data;
            idx_q    <= IDX_W'(1);
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (op_fire) begin
            w_en_q   <= 1'b1;
            addr_q   <= idx_addr;
            w_data_q <= op_data;
            idx_q    <= idx_d;
            if (idx_d == IDX_W'(NWORDS)) op_ready_q <= 1'b0;
          end else if (idx_q == IDX_W'(NWORDS)) begin
            w_en_q   <= 1'b1;
            addr_q   <= CTRL_ADDR;
            w_data_q <= DATA_W'(1);
            state_q  <= TRIG;
          end
        end
        TRIG: begin
          r_en_q  <= 1'b1;
          addr_q  <= STATUS_ADDR;
          state_q <= POLL;
        end
        POLL: state_q <= POLL_WAIT;
        POLL_WAIT: begin
          if (r_data[DONE_BIT]) begin
            r_en_q  <= 1'b1;
            addr_q  <= RESULT_ADDR;
            state_q <= RD;
          end else if (poll_d == PCNT_W'(MAX_POLLS)) begin
            poll_q        <= poll_d;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            res_data_q    <= '0;
            state_q       <= RESP;
          end else begin
            poll_q  <= poll_d;
            r_en_q  <= 1'b1;
            addr_q  <= STATUS_ADDR;
            state_q <= POLL;
          end
        end
        RD: state_q <= RD_WAIT;
        RD_WAIT: begin
          res_data_q    <= r_data;
          res_timeout_q <= 1'b0;
          res_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b1;
            idx_q       <= '0;
            poll_q      <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready    = op_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign addr        = addr_q;
  assign w_data      = w_data_q;
  assign w_en        = w_en_q;
  assign r_en        = r_en_q;

endmodule

// File: tb/tb_ml_accel_master.sv
// Scoreboard bench for ml_accel_master against a small accelerator register model.
module tb_ml_accel_master;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam logic [AW-1:0] CTRL_A   = 6'h20;
  localparam logic [AW-1:0] RESULT_A = 6'h24;
  localparam logic [AW-1:0] STATUS_A = 6'h28;

  typedef logic [DW-1:0] job_t [8];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid, op_ready, res_valid, res_ready, res_timeout, busy;
  logic [DW-1:0] op_data, res_data, w_data;
  logic [DW-1:0] r_data = '0;
  logic [AW-1:0] addr;
  logic          w_en, r_en;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ml_accel_master #(.VEC_LEN(4), .ADDR_W(AW), .DATA_W(DW), .CTRL_ADDR(CTRL_A),
                    .RESULT_ADDR(RESULT_A), .STATUS_ADDR(STATUS_A), .DONE_BIT(0),
                    .MAX_POLLS(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy), .addr(addr), .w_data(w_data),
    .w_en(w_en), .r_en(r_en), .r_data(r_data));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // accelerator register model
  logic [DW-1:0] regs [0:7];
  logic [DW-1:0] result_m = '0;
  int            stat_m = 0;
  int            done_after = 1;
  logic          ovr_en = 1'b0;
  logic [DW-1:0] ovr_val = '0;

  function automatic logic [DW-1:0] dot();
    logic [DW-1:0] a;
    a = '0;
    for (int i = 0; i < 4; i++) a = a + regs[i] * regs[i+4];
    return a;
  endfunction

  always @(posedge clk) begin
    if (w_en) begin
      if (addr == CTRL_A) begin
        result_m <= dot();
        stat_m   <= 0;
      end else if (addr < CTRL_A) begin
        regs[addr[4:2]] <= w_data;
      end
    end
    if (r_en) begin
      if (addr == STATUS_A) begin
        stat_m <= stat_m + 1;
        r_data <= (done_after != 0 && stat_m + 1 >= done_after) ? 32'h1 : 32'hFFFF_FFFE;
      end else if (addr == RESULT_A) begin
        r_data <= ovr_en ? ovr_val : result_m;
      end else begin
        r_data <= '0;
      end
    end
  end

  // scoreboard monitor
  logic [AW+DW-1:0] exp_wr [$];
  logic [DW:0]      exp_res [$];
  int   stat_reads = 0;
  int   res_reads = 0;
  int   first_acc_cyc = 0;
  int   last_lat = -1;
  logic acc_prev = 1'b0;
  logic rv_prev = 1'b0;

  always @(negedge clk) begin
    chk("bus_excl", 64'(w_en & r_en), 64'(0));
    if (acc_prev || (w_en && addr < CTRL_A))
      chk("wr_timing", 64'(w_en && addr < CTRL_A), 64'(acc_prev));
    if (w_en) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", addr, w_data);
      end else begin
        chk("wr", 64'({addr, w_data}), 64'(exp_wr.pop_front()));
      end
    end
    if (r_en && addr == STATUS_A) stat_reads++;
    if (r_en && addr == RESULT_A) res_reads++;
    if (res_valid && !rv_prev) last_lat = cyc - first_acc_cyc;
    if (res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        checks++; errors++;
        $display("FAIL res_unexpected: got 0x%0h expected no result", res_data);
      end else begin
        chk("res", 64'({res_timeout, res_data}), 64'(exp_res.pop_front()));
      end
    end
    if (op_valid && op_ready && rst && !busy) first_acc_cyc = cyc;
    acc_prev = op_valid && op_ready && rst;
    rv_prev  = res_valid;
  end

  task automatic check_reset();
    chk("rst_flags", 64'({op_ready, res_valid, res_timeout, busy, w_en, r_en}), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_wdata", 64'(w_data), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
  endtask

  // called and returns at posedge+1
  task automatic push_word(input logic [DW-1:0] d);
    int t = 0;
    op_valid = 1'b1;
    op_data  = d;
    @(negedge clk);
    while (!op_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL push_timeout: op_ready stayed 0 expected 1");
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic run_job(input job_t w, input int gap, input int hold,
                         input logic [DW-1:0] exp_data, input logic exp_to);
    int t;
    for (int i = 0; i < 8; i++) exp_wr.push_back({AW'(4*i), w[i]});
    exp_wr.push_back({CTRL_A, 32'h1});
    exp_res.push_back({exp_to, exp_data});
    if (hold > 0) res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_word(w[i]);
      if (i < 7) repeat (gap) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    chk("op_ready_drop", 64'(op_ready), 64'(0));
    if (hold > 0) begin
      t = 0;
      while (!res_valid && t < 3000) begin @(negedge clk); t++; end
      chk("res_valid_seen", 64'(res_valid), 64'(1));
      for (int i = 0; i < hold; i++) begin
        chk("backpressure", 64'({res_valid, busy, op_ready, w_en, r_en, res_timeout, res_data}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_to, exp_data}));
        @(negedge clk);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
    end else begin
      @(posedge clk); #1;
    end
    t = 0;
    while (exp_res.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) begin
      checks++; errors++;
      $display("FAIL job_timeout: result never handshaken");
    end
    chk("wr_drain", 64'(exp_wr.size()), 64'(0));
    @(negedge clk);
    chk("after_hs", 64'({busy, res_valid, op_ready}), 64'({1'b0, 1'b0, 1'b1}));
    @(posedge clk); #1;
  endtask

  initial begin
    int s0, r0;
    op_valid = 1'b0; op_data = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // reference job: 1*5+2*6+3*7+4*8 = 70
    s0 = stat_reads; r0 = res_reads;
    run_job('{1, 2, 3, 4, 5, 6, 7, 8}, 0, 0, 32'd70, 1'b0);
    chk("ref_latency", 64'(last_lat), 64'(14));
    chk("ref_stat_reads", 64'(stat_reads - s0), 64'(1));
    chk("ref_res_reads", 64'(res_reads - r0), 64'(1));

    // back-to-back: 10*14+11*15+12*16+13*17 = 718
    run_job('{10, 11, 12, 13, 14, 15, 16, 17}, 0, 0, 32'd718, 1'b0);
    chk("b2b_latency", 64'(last_lat), 64'(14));

    // gapped: 1*2 * 4 = 8
    run_job('{1, 1, 1, 1, 2, 2, 2, 2}, 2, 0, 32'd8, 1'b0);

    // late DONE on 3rd status read
    done_after = 3; ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    s0 = stat_reads; r0 = res_reads;
    run_job('{1, 2, 3, 4, 5, 6, 7, 8}, 0, 0, 32'hDEAD_BEEF, 1'b0);
    chk("late_stat_reads", 64'(stat_reads - s0), 64'(3));
    chk("late_res_reads", 64'(res_reads - r0), 64'(1));
    chk("late_latency", 64'(last_lat), 64'(18));

    // timeout: DONE never set, MAX_POLLS = 4
    done_after = 0; ovr_en = 1'b0;
    s0 = stat_reads; r0 = res_reads;
    run_job('{9, 9, 9, 9, 9, 9, 9, 9}, 0, 0, 32'd0, 1'b1);
    chk("to_stat_reads", 64'(stat_reads - s0), 64'(4));
    chk("to_res_reads", 64'(res_reads - r0), 64'(0));

    // backpressure: 3*100 = 300
    done_after = 1;
    run_job('{0, 0, 0, 3, 0, 0, 0, 100}, 0, 10, 32'd300, 1'b0);

    // mid-load reset after 3 accepted words
    exp_wr.push_back({6'h00, 32'd50});
    exp_wr.push_back({6'h04, 32'd51});
    exp_wr.push_back({6'h08, 32'd52});
    push_word(32'd50);
    push_word(32'd51);
    push_word(32'd52);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    chk("abort_wr_drain", 64'(exp_wr.size()), 64'(0));
    @(posedge clk); #1;
    // 2*6+3*7+4*8+5*9 = 110
    run_job('{2, 3, 4, 5, 6, 7, 8, 9}, 0, 0, 32'd110, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
